// File: rtl/dual_issue_hazard_ctl.sv
// Issue/hazard controller for the dual-issue MIPS pipeline: scoreboard, stall/kill, split issue, branch flush.
// Optional performance counters are enabled with `define DI_HAZARD_PERF_EN.
module dual_issue_hazard_ctl #(
  parameter int WB_BYPASS = 1,
  parameter int REG_BITS  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] s0_rs,
  input  logic [REG_BITS-1:0] s0_rt,
  input  logic                s0_use_rs,
  input  logic                s0_use_rt,
  input  logic [REG_BITS-1:0] s0_dst,
  input  logic                s0_regwrite,
  input  logic [REG_BITS-1:0] s1_rs,
  input  logic [REG_BITS-1:0] s1_rt,
  input  logic                s1_use_rt,
  input  logic                s1_regwrite,
  input  logic                pcsrc,
`ifdef DI_HAZARD_PERF_EN
  output logic [15:0]         stall_cnt,
  output logic [15:0]         split_cnt,
  output logic [15:0]         flush_cnt,
`endif
  output logic                stall_s1_s2,
  output logic                kill0_s2,
  output logic                kill1_s2,
  output logic                flush_s1,
  output logic                split_active
);

  typedef enum logic {ST_RUN, ST_SPLIT} state_t;

  // Entry index = 2*row + slot, rows ordered SB3, SB4, SB5.
  localparam int NCHK = (WB_BYPASS != 0) ? 4 : 6;

  state_t              state_q, state_d;
  logic [5:0]          ent_v_q;
  logic [REG_BITS-1:0] ent_r_q [6];
  logic                raw0, raw1, intra;

  always_comb begin
    raw0 = 1'b0;
    raw1 = 1'b0;
    for (int i = 0; i < NCHK; i++) begin
      if (ent_v_q[i]) begin
        if (s0_use_rs && (s0_rs != '0) && (s0_rs == ent_r_q[i])) raw0 = 1'b1;
        if (s0_use_rt && (s0_rt != '0) && (s0_rt == ent_r_q[i])) raw0 = 1'b1;
        if ((s1_rs != '0) && (s1_rs == ent_r_q[i]))              raw1 = 1'b1;
        if (s1_use_rt && (s1_rt != '0) && (s1_rt == ent_r_q[i])) raw1 = 1'b1;
      end
    end
  end

  // Same destination in both slots is a dual write conflict and is split as well.
  assign intra = s0_regwrite && (s0_dst != '0) &&
                 ((s0_dst == s1_rs) || ((s1_use_rt || s1_regwrite) && (s0_dst == s1_rt)));

  always_comb begin
    state_d      = state_q;
    stall_s1_s2  = 1'b0;
    kill0_s2     = 1'b1;
    kill1_s2     = 1'b1;
    flush_s1     = 1'b0;
    split_active = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          if (id_valid) begin
            if (raw0 || raw1) begin
              stall_s1_s2 = 1'b1;
            end else if (intra) begin
              stall_s1_s2 = 1'b1;
              kill0_s2    = 1'b0;
              state_d     = ST_SPLIT;
            end else begin
              kill0_s2 = 1'b0;
              kill1_s2 = 1'b0;
            end
          end
          flush_s1 = pcsrc && !kill0_s2;
        end
        ST_SPLIT: begin
          split_active = 1'b1;
          if (raw1) begin
            stall_s1_s2 = 1'b1;
          end else begin
            kill1_s2 = 1'b0;
            state_d  = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      ent_v_q <= '0;
      for (int i = 0; i < 6; i++) ent_r_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ent_v_q[5:2] <= ent_v_q[3:0];
      for (int i = 2; i < 6; i++) ent_r_q[i] <= ent_r_q[i-2];
      ent_v_q[0]   <= s0_regwrite && !kill0_s2 && (s0_dst != '0);
      ent_r_q[0]   <= s0_dst;
      ent_v_q[1]   <= s1_regwrite && !kill1_s2 && (s1_rt != '0);
      ent_r_q[1]   <= s1_rt;
    end
  end

`ifdef DI_HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, split_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      split_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_s1_s2 && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if ((state_q == ST_RUN) && (state_d == ST_SPLIT) && (split_cnt_q != 16'hFFFF))
        split_cnt_q <= split_cnt_q + 16'd1;
      if (flush_s1 && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign split_cnt = split_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_dual_issue_hazard_ctl.sv
// Bench for dual_issue_hazard_ctl: directed pipeline scenarios plus random pairs against an in-flight-write model.
// Counter checks are included when DI_HAZARD_PERF_EN is defined.
module tb_dual_issue_hazard_ctl;
  localparam int WB_BYPASS = 1;
  localparam int RB        = 5;
  localparam int LIM       = (WB_BYPASS != 0) ? 2 : 3;

  logic          clk, reset, id_valid, pcsrc;
  logic [RB-1:0] s0_rs, s0_rt, s0_dst, s1_rs, s1_rt;
  logic          s0_use_rs, s0_use_rt, s0_regwrite, s1_use_rt, s1_regwrite;
  logic          stall_s1_s2, kill0_s2, kill1_s2, flush_s1, split_active;
`ifdef DI_HAZARD_PERF_EN
  logic [15:0]   stall_cnt, split_cnt, flush_cnt;
  int            m_stall_cnt, m_split_cnt, m_flush_cnt;
`endif

  dual_issue_hazard_ctl #(.WB_BYPASS(WB_BYPASS), .REG_BITS(RB)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .s0_rs(s0_rs), .s0_rt(s0_rt), .s0_use_rs(s0_use_rs), .s0_use_rt(s0_use_rt),
    .s0_dst(s0_dst), .s0_regwrite(s0_regwrite),
    .s1_rs(s1_rs), .s1_rt(s1_rt), .s1_use_rt(s1_use_rt), .s1_regwrite(s1_regwrite),
    .pcsrc(pcsrc),
`ifdef DI_HAZARD_PERF_EN
    .stall_cnt(stall_cnt), .split_cnt(split_cnt), .flush_cnt(flush_cnt),
`endif
    .stall_s1_s2(stall_s1_s2), .kill0_s2(kill0_s2), .kill1_s2(kill1_s2),
    .flush_s1(flush_s1), .split_active(split_active)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: list of issued writes with their age (1 = stage 3)
  typedef struct {int r; int age;} wr_t;
  wr_t        wq[$];
  bit         m_split;
  bit         e_stall, e_k0, e_k1, e_fl, e_sp, m_raw0, m_raw1, m_intra;
  logic [4:0] exp_q[$];
  logic [4:0] obs;
  int         tests_run, tests_failed;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit busy(input int r);
    if (r == 0) return 1'b0;
    foreach (wq[i]) if (wq[i].r == r && wq[i].age <= LIM) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_eval();
    m_raw0  = (s0_use_rs && busy(int'(s0_rs))) || (s0_use_rt && busy(int'(s0_rt)));
    m_raw1  = busy(int'(s1_rs)) || (s1_use_rt && busy(int'(s1_rt)));
    m_intra = s0_regwrite && s0_dst != 0 &&
              (s0_dst == s1_rs || ((s1_use_rt || s1_regwrite) && s0_dst == s1_rt));
    e_stall = 0; e_k0 = 1; e_k1 = 1; e_fl = 0; e_sp = 0;
    if (!reset) begin
      if (m_split) begin
        e_sp = 1;
        e_stall = m_raw1;
        e_k1 = m_raw1;
      end else begin
        if (id_valid) begin
          if (m_raw0 || m_raw1) e_stall = 1;
          else if (m_intra) begin e_stall = 1; e_k0 = 0; end
          else begin e_k0 = 0; e_k1 = 0; end
        end
        e_fl = pcsrc && !e_k0;
      end
    end
    exp_q.push_back({e_stall, e_k0, e_k1, e_fl, e_sp});
  endtask

  task automatic model_commit();
    if (reset) begin
      wq.delete();
      m_split = 0;
`ifdef DI_HAZARD_PERF_EN
      m_stall_cnt = 0; m_split_cnt = 0; m_flush_cnt = 0;
`endif
    end else begin
`ifdef DI_HAZARD_PERF_EN
      if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
      if (e_fl && m_flush_cnt < 65535) m_flush_cnt++;
      if (!m_split && id_valid && !(m_raw0 || m_raw1) && m_intra && m_split_cnt < 65535) m_split_cnt++;
`endif
      foreach (wq[i]) wq[i].age++;
      for (int i = wq.size() - 1; i >= 0; i--) if (wq[i].age > 3) wq.delete(i);
      if (!e_k0 && s0_regwrite && s0_dst != 0) wq.push_back('{int'(s0_dst), 1});
      if (!e_k1 && s1_regwrite && s1_rt != 0)  wq.push_back('{int'(s1_rt), 1});
      if (!m_split && id_valid && !(m_raw0 || m_raw1) && m_intra) m_split = 1;
      else if (m_split && !m_raw1) m_split = 0;
    end
  endtask

  // one cycle: sample at negedge, compare through scoreboard, advance model at posedge
  task automatic step();
    logic [4:0] e;
    @(negedge clk);
    model_eval();
    obs = {stall_s1_s2, kill0_s2, kill1_s2, flush_s1, split_active};
    e = exp_q.pop_front();
    check("stall", 16'(obs[4]), 16'(e[4]));
    check("kill0", 16'(obs[3]), 16'(e[3]));
    check("kill1", 16'(obs[2]), 16'(e[2]));
    check("flush", 16'(obs[1]), 16'(e[1]));
    check("split", 16'(obs[0]), 16'(e[0]));
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // driver tasks
  task automatic set_s0(input int rs, input int rt, input bit urs, input bit urt, input int dst, input bit rw);
    s0_rs = RB'(rs); s0_rt = RB'(rt); s0_use_rs = urs; s0_use_rt = urt;
    s0_dst = RB'(dst); s0_regwrite = rw;
  endtask

  task automatic set_s1(input int rs, input int rt, input bit urt, input bit rw);
    s1_rs = RB'(rs); s1_rt = RB'(rt); s1_use_rt = urt; s1_regwrite = rw;
  endtask

  task automatic idle(input int n);
    id_valid = 0; pcsrc = 0;
    set_s0(0, 0, 0, 0, 0, 0);
    set_s1(0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  // run until the held pair issues; returns number of stalled cycles
  task automatic until_issue(output int stalls, input string tag);
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!obs[4]) return;
      stalls++;
    end
    check({tag, "_timeout"}, 16'(stalls), 16'(0));
  endtask

  initial begin
    int n;
    tests_run = 0; tests_failed = 0; m_split = 0;
`ifdef DI_HAZARD_PERF_EN
    m_stall_cnt = 0; m_split_cnt = 0; m_flush_cnt = 0;
`endif
    reset = 1; id_valid = 1; pcsrc = 1;
    set_s0(1, 2, 1, 1, 3, 1);
    set_s1(4, 5, 0, 1);

    // reset held two cycles with a live, branching pair
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_stall", 16'(obs[4]), 16'(0));
      check("rst_kill0", 16'(obs[3]), 16'(1));
      check("rst_kill1", 16'(obs[2]), 16'(1));
      check("rst_flush", 16'(obs[1]), 16'(0));
    end
    reset = 0; pcsrc = 0;
    step();
    check("clean_kill0", 16'(obs[3]), 16'(0));
    check("clean_kill1", 16'(obs[2]), 16'(0));
    idle(4);

    // LW r5 then a slot-0 reader of r5
    id_valid = 1;
    set_s1(1, 5, 0, 1);
    step();
    set_s0(5, 0, 1, 0, 6, 1);
    set_s1(0, 0, 0, 0);
    until_issue(n, "lw_use");
    check("lw_use_stalls", 16'(n), 16'(LIM));
    check("lw_use_kill0", 16'(obs[3]), 16'(0));
    check("lw_use_kill1", 16'(obs[2]), 16'(0));
    idle(4);

    // ADD r3,r1,r2 / SW r3,0(r4): split issue
    id_valid = 1;
    set_s0(1, 2, 1, 1, 3, 1);
    set_s1(4, 3, 1, 0);
    step();
    check("split0_stall", 16'(obs[4]), 16'(1));
    check("split0_kill0", 16'(obs[3]), 16'(0));
    check("split0_kill1", 16'(obs[2]), 16'(1));
    until_issue(n, "split");
    check("split_dwell", 16'(n), 16'(LIM));
    check("split_end_kill0", 16'(obs[3]), 16'(1));
    check("split_end_kill1", 16'(obs[2]), 16'(0));
    check("split_end_active", 16'(obs[0]), 16'(1));
    set_s0(0, 0, 0, 0, 0, 0);
    set_s1(0, 0, 0, 0);
    step();
    check("split_back_run", 16'(obs[0]), 16'(0));
    idle(4);

    // ADDI r7 / LW r7: write-write conflict split
    id_valid = 1;
    set_s0(1, 0, 1, 0, 7, 1);
    set_s1(2, 7, 0, 1);
    step();
    check("waw_kill0", 16'(obs[3]), 16'(0));
    check("waw_kill1", 16'(obs[2]), 16'(1));
    until_issue(n, "waw");
    check("waw_issue_kill1", 16'(obs[2]), 16'(0));
    idle(4);

    // BEQ taken, no hazard
    id_valid = 1; pcsrc = 1;
    set_s0(1, 2, 1, 1, 0, 0);
    step();
    check("beq_flush", 16'(obs[1]), 16'(1));
    check("beq_kill1", 16'(obs[2]), 16'(0));
    idle(4);

    // BEQ taken while its source is still in flight
    id_valid = 1;
    set_s1(3, 1, 0, 1);
    step();
    pcsrc = 1;
    set_s0(1, 2, 1, 1, 0, 0);
    set_s1(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (!obs[4]) break;
      check("beq_stall_flush", 16'(obs[1]), 16'(0));
    end
    check("beq_release_flush", 16'(obs[1]), 16'(1));
    idle(4);

    // destination r0 never creates a hazard
    id_valid = 1;
    set_s0(1, 2, 1, 1, 0, 1);
    step();
    set_s0(0, 0, 1, 1, 8, 1);
    set_s1(0, 0, 1, 0);
    step();
    check("r0_stall", 16'(obs[4]), 16'(0));
    idle(4);

    // randomized pairs; a stalled pair stays in IF/ID
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      if (!obs[4] || reset) begin
        id_valid = ($urandom_range(0, 7) != 0);
        set_s0($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        set_s1($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
      pcsrc = ($urandom_range(0, 3) == 0);
      step();
    end
    reset = 0;
    idle(2);

`ifdef DI_HAZARD_PERF_EN
    @(negedge clk);
    check("stall_cnt", stall_cnt, 16'(m_stall_cnt));
    check("split_cnt", split_cnt, 16'(m_split_cnt));
    check("flush_cnt", flush_cnt, 16'(m_flush_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/dual_issue_hazard_ctl.md
Name: dual_issue_hazard_ctl

Overview:
Issue/hazard controller for the dual-issue five-stage MIPS pipeline. Slot 0 carries ALU/ADDI/BEQ/BNE; slot 1 carries LW/SW. The pipeline has no forwarding, so this block tracks every in-flight register write in a scoreboard. From that it drives the IF/ID hold, per-slot bubble injection into ID/EX, the split-issue sequence for intra-pair dependencies, and the IF/ID flush on taken branches.

Parameters:
WB_BYPASS, 1, 1 = register file writes before the ID read in the same cycle, so a producer in stage 5 causes no hazard; 0 = stage-5 producers also stall.
REG_BITS, 5, register index width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  IF/ID holds a real instruction pair (0 after flush or startup)
s0_rs  in  5  slot-0 rs
s0_rt  in  5  slot-0 rt
s0_use_rs  in  1  slot 0 reads rs
s0_use_rt  in  1  slot 0 reads rt (R-type, BEQ/BNE)
s0_dst  in  5  slot-0 destination (rd or rt after regdst)
s0_regwrite  in  1  slot 0 writes a register
s1_rs  in  5  slot-1 base register
s1_rt  in  5  slot-1 rt
s1_use_rt  in  1  slot 1 reads rt (SW store data)
s1_regwrite  in  1  slot 1 is LW (dst = s1_rt)
pcsrc  in  1  branch-taken decision computed in ID
stall_s1_s2  out  1  hold PC and IF/ID
kill0_s2  out  1  zero slot-0 control into ID/EX
kill1_s2  out  1  zero slot-1 control into ID/EX
flush_s1  out  1  clear IF/ID next edge
split_active  out  1  FSM in SPLIT

Behaviour:
- Reset is synchronous and active-high: state=RUN, all scoreboard entries invalid. While reset=1: stall_s1_s2=0, kill0_s2=kill1_s2=1, flush_s1=0, split_active=0.
- Scoreboard: three rows, SB3, SB4 and SB5, one per stage 3/4/5. Each row holds two {valid, reg} entries, one per slot.
  - Each edge: SB5<=SB4, SB4<=SB3.
  - SB3 <= {s0_regwrite & ~kill0_s2, s0_dst} and {s1_regwrite & ~kill1_s2, s1_rt}.
  - Register 0 is never recorded as valid.
- Source hazard: a used source (nonzero) matches a valid entry in SB3 or SB4, or in SB5 when WB_BYPASS=0.
  - raw0 covers slot-0 sources.
  - raw1 covers slot-1 rs plus rt when s1_use_rt=1.
- Intra-pair dependency: s0_regwrite and s0_dst!=0, and s0_dst equals either:
  - s1_rs, or
  - s1_rt when s1_use_rt | s1_regwrite. Same destination counts as a WAW dual-port write conflict.
- FSM RUN, when id_valid=0: stall=0, kill0=kill1=1.
- FSM RUN, when id_valid=1:
  - raw0|raw1: stall=1, kill0=kill1=1, stay in RUN. The pair is issued jointly, never partially.
  - else intra-pair dependency: stall=1, kill0=0, kill1=1, go to SPLIT.
  - else: stall=0, kill0=kill1=0.
- FSM SPLIT (the pair is still held in IF/ID):
  - kill0=1 always.
  - raw1 (now including slot 0's dst in SB3): stall=1, kill1=1.
  - else: stall=0, kill1=0, return to RUN.
  - Minimum SPLIT dwell is 2 cycles with WB_BYPASS=1, 3 cycles with WB_BYPASS=0.
- Branch: flush_s1 = pcsrc & ~kill0_s2 & (state==RUN), combinational, same cycle.
  - pcsrc is ignored while stalled, killed, or in SPLIT.
  - The slot-1 instruction of the branch pair still issues; the next fetched pair is flushed.
- Outputs are combinational from state, scoreboard and current inputs. Scoreboard and state update on posedge only.
- Reset asserted mid-SPLIT returns to RUN next edge and discards the pending slot-1 issue. Reset also clears in-flight scoreboard entries.

Optional Feature:
Macro DI_HAZARD_PERF_EN.
- Defined: adds outputs stall_cnt[15:0], split_cnt[15:0] and flush_cnt[15:0], each saturating at 16'hFFFF and cleared by reset.
  - stall_cnt counts cycles with stall_s1_s2=1.
  - split_cnt counts RUN->SPLIT transitions.
  - flush_cnt counts cycles with flush_s1=1.
- Undefined: the ports and counters are absent; the core behaviour is identical.

Test Plan:
- Reset held 2 cycles with id_valid=1 and pcsrc=1 -> kill0=kill1=1, stall=0 and flush_s1=0 throughout. After release, a clean pair issues with kill0=kill1=0.
- LW r5 issued (slot 1), then the next pair reads r5 in slot 0 (WB_BYPASS=1) -> stall=1 for exactly 2 cycles, then issue with kill0=kill1=0. With WB_BYPASS=0 the stall lasts 3 cycles.
- Pair ADD r3,r1,r2 / SW r3,0(r4) with a clean scoreboard -> cycle 0: stall=1, kill0=0, kill1=1, split_active rises. Cycles 1-2: stall=1, kill1=1. Cycle 3: stall=0, kill1=0, back in RUN.
- Pair ADDI r7 / LW r7 -> treated as a split (WAW); the SB3 slot-0 entry reg=7 is recorded first, and the slot-1 write follows.
- BEQ in slot 0 with pcsrc=1 and no hazard -> flush_s1=1 for one cycle, kill1=0. The same BEQ with pcsrc=1 while raw0=1 -> flush_s1=0 until the stall clears.
- Destination r0 (ADD r0,r1,r2 followed by a reader of r0) -> no stall, no scoreboard entry.
